mul_sched: RTL

Sequencer and two-port arbiter for the shared RV32M multiplier datapath. It accepts multiply requests from two requesters (core execute stage on port 0, a secondary master on port 1) over valid/ready handshakes and arbitrates round-robin. It holds registered operands on the internal `mul` instance for `LATENCY` cycles, treating the multiplier as a multicycle path, then returns the registered result on a response handshake. A one-entry result cache short-circuits exact repeats of the previous operation.

---
 rtl/mul_sched.sv | 232 +++++++++++++++++++++++
 1 files changed

// File: rtl/mul_sched.sv
// mul_sched: round-robin two-port sequencer for the shared RV32M multiplier.
// Operands are registered and held on the multiplier for LATENCY cycles, so
// the multiplier is a multicycle path. The result comes back on a one-hot
// response handshake. A one-entry cache answers an exact repeat of the last
// completed operation without going through the multiplier.

`default_nettype none

package mul_sched_pkg;
   // Encodings follow the RV32M funct3 field. The other four values are illegal.
   typedef enum logic [2:0] {
      MUL_MUL    = 3'b000,
      MUL_MULH   = 3'b001,
      MUL_MULHSU = 3'b010,
      MUL_MULHU  = 3'b011
   } mul_op_t;
endpackage

// Combinational 32x32 multiplier. Each operand is extended to 33 bits, so a
// single signed product covers the signed, unsigned and mixed forms.
module mul
   import mul_sched_pkg::*;
(
   input  logic [31:0] a_i,
   input  logic [31:0] b_i,
   input  logic [2:0]  op_i,
   output logic [31:0] res_o
);

   logic               a_sgn;
   logic               b_sgn;
   logic               legal;
   logic               low_half;
   logic signed [32:0] a_ext;
   logic signed [32:0] b_ext;
   logic signed [63:0] prod;

   // Decode the operation into operand signedness and the product half to return.
   always_comb begin
      // NOTE: give every always_comb output a default first, so no path can infer a latch.
      a_sgn    = 1'b0;
      b_sgn    = 1'b0;
      legal    = 1'b1;
      low_half = 1'b0;
      case (op_i)
         MUL_MUL:    low_half = 1'b1;
         MUL_MULH:   begin a_sgn = 1'b1; b_sgn = 1'b1; end
         MUL_MULHSU: a_sgn = 1'b1;
         MUL_MULHU:  ;
         default:    legal = 1'b0;
      endcase
   end

   assign a_ext = {a_sgn & a_i[31], a_i};
   assign b_ext = {b_sgn & b_i[31], b_i};
   // The low 64 bits of the 66-bit signed product are exact for every form.
   assign prod  = 64'(a_ext) * 64'(b_ext);

   // Select the product half. Illegal encodings return zero.
   always_comb begin
      res_o = 32'd0;
      if (legal) begin
         res_o = low_half ? prod[31:0] : prod[63:32];
      end
   end

endmodule

module mul_sched #(
   parameter int unsigned LATENCY = 2   // legal range 1..15
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [1:0]       req_valid,
   output logic [1:0]       req_ready,
   input  logic [1:0][31:0] req_a,
   input  logic [1:0][31:0] req_b,
   input  logic [1:0][2:0]  req_op,
   output logic [1:0]       rsp_valid,
   input  logic [1:0]       rsp_ready,
   output logic [31:0]      rsp_res,
   output logic             busy
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_EXEC = 2'd1,
      S_RESP = 2'd2
   } state_t;

   localparam logic [3:0] LAST_CNT = 4'(LATENCY - 1);

   state_t      state_q;
   logic [31:0] a_q;
   logic [31:0] b_q;
   logic [2:0]  op_q;
   logic        id_q;
   logic [31:0] res_q;
   logic [3:0]  cnt_q;
   logic [3:0]  cnt_d;
   logic        last_q;
   logic [1:0]  rsp_valid_q;
   logic        busy_q;

   logic        cache_vld_q;
   logic [31:0] cache_a_q;
   logic [31:0] cache_b_q;
   logic [2:0]  cache_op_q;
   logic [31:0] cache_res_q;

   logic        grant_vld;
   logic        grant_id;
   logic [31:0] acc_a;
   logic [31:0] acc_b;
   logic [2:0]  acc_op;
   logic        cache_hit;
   logic        exec_done;
   logic [31:0] mul_res;

   // The multiplier sees only the registered operands, never the request bus.
   mul u_mul (
      .a_i   (a_q),
      .b_i   (b_q),
      .op_i  (op_q),
      .res_o (mul_res)
   );

   // Round-robin arbitration. A grant is offered only in IDLE and outside reset.
   always_comb begin
      grant_vld = 1'b0;
      grant_id  = 1'b0;
      if (state_q == S_IDLE && !reset) begin
         case (req_valid)
            2'b01:   begin grant_vld = 1'b1; grant_id = 1'b0;    end
            2'b10:   begin grant_vld = 1'b1; grant_id = 1'b1;    end
            2'b11:   begin grant_vld = 1'b1; grant_id = ~last_q; end
            default: ;
         endcase
      end
   end

   assign req_ready = grant_vld ? (grant_id ? 2'b10 : 2'b01) : 2'b00;

   // Operands of the granted requester, and the cache lookup on them.
   assign acc_a     = req_a[grant_id];
   assign acc_b     = req_b[grant_id];
   assign acc_op    = req_op[grant_id];
   assign cache_hit = cache_vld_q && (cache_a_q == acc_a) && (cache_b_q == acc_b)
                      && (cache_op_q == acc_op);

   assign cnt_d     = cnt_q + 4'd1;
   assign exec_done = (state_q == S_EXEC) && (cnt_q == LAST_CNT);

   // Sequencer FSM with registered response and busy outputs.
   always_ff @(posedge clk) begin
      // NOTE: all state in clocked blocks uses <=, so every register sees pre-edge values.
      if (reset) begin
         state_q     <= S_IDLE;
         a_q         <= 32'd0;
         b_q         <= 32'd0;
         op_q        <= 3'd0;
         id_q        <= 1'b0;
         res_q       <= 32'd0;
         cnt_q       <= 4'd0;
         last_q      <= 1'b1;
         rsp_valid_q <= 2'b00;
         busy_q      <= 1'b0;
         cache_vld_q <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (grant_vld) begin
                  a_q    <= acc_a;
                  b_q    <= acc_b;
                  op_q   <= acc_op;
                  id_q   <= grant_id;
                  last_q <= grant_id;
                  busy_q <= 1'b1;
                  if (cache_hit) begin
                     res_q       <= cache_res_q;
                     rsp_valid_q <= grant_id ? 2'b10 : 2'b01;
                     state_q     <= S_RESP;
                  end else begin
                     cnt_q   <= 4'd0;
                     state_q <= S_EXEC;
                  end
               end
            end
            S_EXEC: begin
               cnt_q <= cnt_d;
               if (exec_done) begin
                  res_q       <= mul_res;
                  cache_vld_q <= 1'b1;
                  rsp_valid_q <= id_q ? 2'b10 : 2'b01;
                  state_q     <= S_RESP;
               end
            end
            S_RESP: begin
               // Only the owning requester's ready completes the response.
               if (rsp_ready[id_q]) begin
                  rsp_valid_q <= 2'b00;
                  busy_q      <= 1'b0;
                  state_q     <= S_IDLE;
               end
            end
            default: begin
               rsp_valid_q <= 2'b00;
               busy_q      <= 1'b0;
               state_q     <= S_IDLE;
            end
         endcase
      end
   end

   // Cache payload: written when a multiplier result is captured.
   always_ff @(posedge clk) begin
      // NOTE: payload needs no reset; cache_vld_q is reset and gates every use of it.
      if (exec_done) begin
         cache_a_q   <= a_q;
         cache_b_q   <= b_q;
         cache_op_q  <= op_q;
         cache_res_q <= mul_res;
      end
   end

   assign rsp_valid = rsp_valid_q;
   assign rsp_res   = res_q;
   assign busy      = busy_q;

endmodule

`default_nettype wire
